// File: rtl/commit_stage_if.sv
// Bundle of the Execute, memory-response, Fetch-update and RegFile-write signals
// that surround the commit stage; master is the environment, slave is the stage.
interface commit_stage_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic            ex_is_cond_br;
    logic            ex_is_link;
    logic            ex_cmp_out;
    logic [XLEN-1:0] ex_alu_out;
    logic [XLEN-1:0] ex_pred_next_pc;
    logic [4:0]      ex_rd;
    logic [1:0]      ex_wsrc;
    logic [2:0]      ex_ld_funct3;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            fetch_upd_valid;
    logic            fetch_upd_taken;
    logic            fetch_upd_mispred;
    logic            fetch_upd_uncond;
    logic [XLEN-1:0] fetch_upd_addr;
    logic [XLEN-1:0] fetch_upd_target;
    logic            flush;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    modport master (
        output ex_valid, ex_pc, ex_is_cond_br, ex_is_link, ex_cmp_out, ex_alu_out,
               ex_pred_next_pc, ex_rd, ex_wsrc, ex_ld_funct3, mem_rsp_valid, mem_rsp_data,
        input  ex_ready, fetch_upd_valid, fetch_upd_taken, fetch_upd_mispred,
               fetch_upd_uncond, fetch_upd_addr, fetch_upd_target, flush,
               rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  ex_valid, ex_pc, ex_is_cond_br, ex_is_link, ex_cmp_out, ex_alu_out,
               ex_pred_next_pc, ex_rd, ex_wsrc, ex_ld_funct3, mem_rsp_valid, mem_rsp_data,
        output ex_ready, fetch_upd_valid, fetch_upd_taken, fetch_upd_mispred,
               fetch_upd_uncond, fetch_upd_addr, fetch_upd_target, flush,
               rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/commit_stage.sv
// Commit stage: resolves branches, writes the register file, completes loads and
// squashes a fixed number of wrong-path instructions after a mispredict.
module commit_stage #(
    parameter int XLEN         = 32,
    parameter int SQUASH_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    commit_stage_if.slave bus
);
    localparam int LANE_W = $clog2(XLEN / 8);
    localparam int CNT_W  = $clog2(SQUASH_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(SQUASH_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);
    localparam logic [XLEN-1:0]  FOUR_C  = XLEN'(4);
    localparam logic [1:0] WSRC_ALU = 2'd0;
    localparam logic [1:0] WSRC_CMP = 2'd1;
    localparam logic [1:0] WSRC_SEQ = 2'd2;
    localparam logic [1:0] WSRC_MEM = 2'd3;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT_MEM = 2'd1, S_SQUASH = 2'd2} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            is_cond;
        logic            is_link;
        logic            cmp;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] pred;
        logic [4:0]      rd;
        logic [1:0]      wsrc;
        logic [2:0]      f3;
    } instr_t;

    state_t          state_q, state_d;
    logic            v_q, v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    instr_t          instr_q, instr_d, ex_instr_s;

    logic            ex_ready_s, xfer_s, commit_s, is_br_s, mispred_s, squash_s;
    logic [XLEN-1:0] seq_pc_s, next_pc_s, wdata_s;

    // The word is shifted so the addressed lane sits at bit 0; narrow sizes then extend.
    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                                 input logic [LANE_W-1:0] lane,
                                                 input logic [XLEN-1:0] data);
        logic [XLEN-1:0] sh;
        sh = data >> {lane, 3'b000};
        case (f3)
            3'b000:  load_ext = XLEN'($signed(sh[7:0]));
            3'b001:  load_ext = XLEN'($signed(sh[15:0]));
            3'b010:  load_ext = XLEN'($signed(sh[31:0]));
            3'b100:  load_ext = XLEN'(sh[7:0]);
            3'b101:  load_ext = XLEN'(sh[15:0]);
            3'b011:  load_ext = (XLEN == 64) ? sh : data;
            3'b110:  load_ext = (XLEN == 64) ? XLEN'(sh[31:0]) : data;
            default: load_ext = data;
        endcase
    endfunction

    assign ex_instr_s = '{pc: bus.ex_pc, is_cond: bus.ex_is_cond_br, is_link: bus.ex_is_link,
                          cmp: bus.ex_cmp_out, alu: bus.ex_alu_out, pred: bus.ex_pred_next_pc,
                          rd: bus.ex_rd, wsrc: bus.ex_wsrc, f3: bus.ex_ld_funct3};

    // Resolve the held instruction: actual next PC, commit condition and write data.
    always_comb begin
        seq_pc_s = instr_q.pc + FOUR_C;
        if (instr_q.is_link || (instr_q.is_cond && instr_q.cmp)) begin
            next_pc_s = instr_q.alu;
        end else begin
            next_pc_s = seq_pc_s;
        end
        is_br_s    = instr_q.is_cond || instr_q.is_link;
        mispred_s  = (next_pc_s != instr_q.pred);
        ex_ready_s = (state_q != S_WAIT_MEM);
        xfer_s     = bus.ex_valid && ex_ready_s;
        commit_s   = v_q && (state_q != S_SQUASH) &&
                     ((instr_q.wsrc != WSRC_MEM) || ((state_q == S_WAIT_MEM) && bus.mem_rsp_valid));
        squash_s   = commit_s && is_br_s && mispred_s;
        case (instr_q.wsrc)
            WSRC_ALU: wdata_s = instr_q.alu;
            WSRC_CMP: wdata_s = XLEN'(instr_q.cmp);
            WSRC_SEQ: wdata_s = seq_pc_s;
            WSRC_MEM: wdata_s = load_ext(instr_q.f3, instr_q.alu[LANE_W-1:0], bus.mem_rsp_data);
            default:  wdata_s = instr_q.alu;
        endcase
    end

    // Next state: a mispredict's own commit-cycle capture already counts as one dropped slot.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        if (squash_s) begin
            v_d   = 1'b0;
            cnt_d = DEPTH_C - CNT_W'(xfer_s);
            state_d = (cnt_d == ZERO_C) ? S_IDLE : S_SQUASH;
        end else if (state_q == S_SQUASH) begin
            v_d = 1'b0;
            if (xfer_s && (cnt_q != ZERO_C)) begin
                cnt_d   = cnt_q - ONE_C;
                state_d = (cnt_q == ONE_C) ? S_IDLE : S_SQUASH;
            end else begin
                state_d = (cnt_q == ZERO_C) ? S_IDLE : S_SQUASH;
            end
        end else if (xfer_s) begin
            v_d     = 1'b1;
            instr_d = ex_instr_s;
            state_d = (bus.ex_wsrc == WSRC_MEM) ? S_WAIT_MEM : S_IDLE;
        end else if (commit_s) begin
            v_d     = 1'b0;
            state_d = S_IDLE;
        end else begin
            v_d = v_q;
        end
    end

    // Stage register, state and squash counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            v_q     <= 1'b0;
            cnt_q   <= ZERO_C;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    assign bus.ex_ready          = ex_ready_s;
    assign bus.fetch_upd_valid   = commit_s && is_br_s;
    assign bus.fetch_upd_taken   = commit_s && (instr_q.is_link || (instr_q.is_cond && instr_q.cmp));
    assign bus.fetch_upd_mispred = squash_s;
    assign bus.fetch_upd_uncond  = commit_s && instr_q.is_link;
    assign bus.fetch_upd_addr    = (commit_s && is_br_s) ? instr_q.pc : '0;
    assign bus.fetch_upd_target  = (commit_s && is_br_s) ? next_pc_s : '0;
    assign bus.flush             = squash_s;
    assign bus.rf_we             = commit_s && (instr_q.rd != 5'd0);
    assign bus.rf_waddr          = bus.rf_we ? instr_q.rd : 5'd0;
    assign bus.rf_wdata          = bus.rf_we ? wdata_s : '0;
endmodule

// File: tb/tb_commit_stage.sv
// Self-checking bench for commit_stage: instruction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_commit_stage;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        cond;
        logic        link;
        logic        cmp;
        logic [31:0] alu;
        logic [31:0] pred;
        logic [4:0]  rd;
        logic [1:0]  wsrc;
        logic [2:0]  f3;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ins_t h;
    bit   have_h = 0;
    int   sq = 0;

    commit_stage_if #(.XLEN(32)) bus ();
    commit_stage #(.XLEN(32), .SQUASH_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(logic [31:0] pc, bit cond, bit link, bit cmp, logic [31:0] alu,
                                logic [31:0] pred, logic [4:0] rd, logic [1:0] wsrc, logic [2:0] f3);
        ins_t i;
        i = '{pc: pc, cond: cond, link: link, cmp: cmp, alu: alu, pred: pred,
              rd: rd, wsrc: wsrc, f3: f3};
        return i;
    endfunction

    function automatic logic [31:0] actual_next(ins_t i);
        if (i.link) return i.alu;
        if (i.cond && i.cmp) return i.alu;
        return i.pc + 32'd4;
    endfunction

    function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] data);
        int          lane;
        logic [31:0] sh;
        int          v;
        lane = int'(addr % 32'd4);
        sh   = data >> (8 * lane);
        case (f3)
            3'd0: begin v = int'(sh & 32'hFF);   if (v > 127)   v -= 256;   return v; end
            3'd1: begin v = int'(sh & 32'hFFFF); if (v > 32767) v -= 65536; return v; end
            3'd2: return sh;
            3'd4: return sh & 32'hFF;
            3'd5: return sh & 32'hFFFF;
            default: return data;
        endcase
    endfunction

    // Compare DUT outputs with the model for this cycle, then advance the model.
    task automatic model_check();
        bit          exp_ready, commit, br, mis, xfer, we;
        logic [31:0] nxt, wd;
        if (rst) begin
            have_h = 0;
            sq     = 0;
        end
        exp_ready = !(have_h && h.wsrc == 2'd3);
        commit    = have_h && (h.wsrc != 2'd3 || bus.mem_rsp_valid);
        br        = h.cond || h.link;
        nxt       = actual_next(h);
        mis       = (nxt != h.pred);
        we        = commit && (h.rd != 5'd0);
        case (h.wsrc)
            2'd0: wd = h.alu;
            2'd1: wd = {31'd0, h.cmp};
            2'd2: wd = h.pc + 32'd4;
            default: wd = exp_load(h.f3, h.alu, bus.mem_rsp_data);
        endcase
        chk("ex_ready", bus.ex_ready, exp_ready);
        chk("upd_valid", bus.fetch_upd_valid, commit && br);
        chk("upd_taken", bus.fetch_upd_taken, commit && br && (h.link || h.cmp));
        chk("upd_mispred", bus.fetch_upd_mispred, commit && br && mis);
        chk("upd_uncond", bus.fetch_upd_uncond, commit && h.link);
        chk("upd_addr", bus.fetch_upd_addr, (commit && br) ? h.pc : 32'd0);
        chk("upd_target", bus.fetch_upd_target, (commit && br) ? nxt : 32'd0);
        chk("flush", bus.flush, commit && br && mis);
        chk("rf_we", bus.rf_we, we);
        chk("rf_waddr", bus.rf_waddr, we ? h.rd : 5'd0);
        chk("rf_wdata", bus.rf_wdata, we ? wd : 32'd0);
        xfer = bus.ex_valid && exp_ready;
        if (!rst) begin
            if (commit && br && mis) begin
                sq     = DEPTH - int'(xfer);
                have_h = 0;
            end else if (sq > 0) begin
                have_h = 0;
                if (xfer) sq--;
            end else if (xfer) begin
                h = mk(bus.ex_pc, bus.ex_is_cond_br, bus.ex_is_link, bus.ex_cmp_out, bus.ex_alu_out,
                       bus.ex_pred_next_pc, bus.ex_rd, bus.ex_wsrc, bus.ex_ld_funct3);
                have_h = 1;
            end else if (commit) begin
                have_h = 0;
            end
        end
    endtask

    task automatic step(input bit rst_v, input bit v, input ins_t i, input bit rv, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        rst                 = rst_v;
        bus.ex_valid        = v;
        bus.ex_pc           = i.pc;
        bus.ex_is_cond_br   = i.cond;
        bus.ex_is_link      = i.link;
        bus.ex_cmp_out      = i.cmp;
        bus.ex_alu_out      = i.alu;
        bus.ex_pred_next_pc = i.pred;
        bus.ex_rd           = i.rd;
        bus.ex_wsrc         = i.wsrc;
        bus.ex_ld_funct3    = i.f3;
        bus.mem_rsp_valid   = rv;
        bus.mem_rsp_data    = rdata;
        #4;
        model_check();
    endtask

    function automatic ins_t rnd_ins();
        ins_t i;
        int   k;
        i.pc   = $urandom & 32'hFFFF_FFFC;
        k      = int'($urandom_range(0, 3));
        i.cond = (k == 0);
        i.link = (k == 1);
        i.cmp  = 1'($urandom_range(0, 1));
        i.alu  = $urandom;
        i.rd   = 5'($urandom_range(0, 31));
        i.wsrc = 2'($urandom_range(0, 3));
        i.f3   = 3'($urandom_range(0, 7));
        i.pred = ($urandom_range(0, 1) == 1) ? actual_next(i) : $urandom;
        return i;
    endfunction

    initial begin
        ins_t z;
        z = '0;
        bus.ex_valid = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        step(1, 0, z, 0, 0);
        step(1, 0, z, 0, 0);
        chk("rst_ready", bus.ex_ready, 1);
        chk("rst_we", bus.rf_we, 0);
        chk("rst_flush", bus.flush, 0);
        step(0, 0, z, 0, 0);

        // back-to-back ALU writes
        step(0, 1, mk(32'h0, 0, 0, 0, 32'd7, 32'h4, 5'd5, 2'd0, 3'd0), 0, 0);
        step(0, 1, mk(32'h4, 0, 0, 0, 32'h30, 32'h8, 5'd6, 2'd0, 3'd0), 0, 0);
        chk("addi_we", bus.rf_we, 1);
        chk("addi_addr", bus.rf_waddr, 5);
        chk("addi_data", bus.rf_wdata, 32'd7);
        step(0, 0, z, 0, 0);
        chk("add_we", bus.rf_we, 1);
        chk("add_addr", bus.rf_waddr, 6);
        chk("add_data", bus.rf_wdata, 32'h30);

        // LB then LBU, response in the third waiting cycle
        for (int s = 0; s < 2; s++) begin
            step(0, 0, z, 0, 0);
            step(0, 1, mk(32'h10, 0, 0, 0, 32'h1002, 32'h14, 5'd3, 2'd3, (s == 0) ? 3'd0 : 3'd4), 0, 0);
            step(0, 1, z, 0, 0);
            chk("ld_wait1", bus.ex_ready, 0);
            step(0, 1, z, 0, 0);
            chk("ld_wait2", bus.ex_ready, 0);
            step(0, 0, z, 1, 32'h0080_0000);
            chk("ld_wait3", bus.ex_ready, 0);
            chk("ld_we", bus.rf_we, 1);
            chk("ld_data", bus.rf_wdata, (s == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            step(0, 0, z, 0, 0);
            chk("ld_ready_back", bus.ex_ready, 1);
        end

        // mispredicted BEQ: commit cycle capture plus three more are dropped
        step(0, 1, mk(32'h100, 1, 0, 1, 32'h200, 32'h104, 5'd0, 2'd0, 3'd0), 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, mk(32'h300 + 32'(4 * k), 0, 0, 0, 32'(k + 1), 32'h0, 5'(10 + k), 2'd0, 3'd0), 0, 0);
            if (k == 0) begin
                chk("beq_taken", bus.fetch_upd_taken, 1);
                chk("beq_mispred", bus.fetch_upd_mispred, 1);
                chk("beq_target", bus.fetch_upd_target, 32'h200);
                chk("beq_flush", bus.flush, 1);
            end else begin
                chk("sq_we", bus.rf_we, 0);
                chk("sq_upd", bus.fetch_upd_valid, 0);
            end
        end
        step(0, 0, z, 0, 0);
        chk("post_sq_we", bus.rf_we, 1);
        chk("post_sq_addr", bus.rf_waddr, 14);

        // JAL correctly predicted
        step(0, 1, mk(32'h40, 0, 1, 0, 32'h80, 32'h80, 5'd1, 2'd2, 3'd0), 0, 0);
        step(0, 0, z, 0, 0);
        chk("jal_data", bus.rf_wdata, 32'h44);
        chk("jal_uncond", bus.fetch_upd_uncond, 1);
        chk("jal_mispred", bus.fetch_upd_mispred, 0);
        chk("jal_flush", bus.flush, 0);

        // x0 write and stray memory response
        step(0, 1, mk(32'h60, 0, 0, 0, 32'd5, 32'h64, 5'd0, 2'd0, 3'd0), 0, 0);
        step(0, 0, z, 1, 32'h1234_5678);
        chk("x0_we", bus.rf_we, 0);
        step(0, 0, z, 1, 32'h1234_5678);
        chk("stray_rsp_we", bus.rf_we, 0);

        // reset while a load waits
        step(0, 1, mk(32'h50, 0, 0, 0, 32'h2000, 32'h54, 5'd7, 2'd3, 3'd2), 0, 0);
        step(1, 0, z, 0, 0);
        chk("rstmid_ready", bus.ex_ready, 1);
        chk("rstmid_we", bus.rf_we, 0);
        step(0, 0, z, 1, 32'hDEAD_BEEF);
        chk("rstmid_rsp_we", bus.rf_we, 0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), rnd_ins(),
                 ($urandom_range(0, 9) < 3), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
